// File: rtl/io_out_hs_fifo.sv
// io_out_hs_fifo: bus-written byte FIFO drained to an external consumer over a dav_/rfd 4-phase handshake.
// Optional sticky overrun status bit enabled by defining IO_OUT_OVERRUN_EN.
module io_out_hs_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_,
    input  logic       ior_,
    input  logic       iow_,
    input  logic       addr,
    inout  wire  [7:0] data,
    output logic [7:0] byte_out,
    output logic       dav_,
    input  logic       rfd
);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_RDY = 2'd3
    } state_t;

    logic [1:0]       s_sync;
    logic [1:0]       iow_sync;
    logic [1:0]       rfd_sync;
    logic             wr_sel;
    logic             wr_sel_d;
    logic             push;
    logic             pop;
    logic             accept;
    logic             full;
    logic             empty;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic             overrun;
    logic [7:0]       rd_data;

    // Two-flop synchronisers for asynchronous bus strobes and consumer ready
    always_ff @(posedge clock) begin
        if (reset) begin
            s_sync   <= 2'b11;
            iow_sync <= 2'b11;
            rfd_sync <= 2'b11;
            wr_sel_d <= 1'b0;
        end else begin
            s_sync   <= {s_sync[0], s_};
            iow_sync <= {iow_sync[0], iow_};
            rfd_sync <= {rfd_sync[0], rfd};
            wr_sel_d <= wr_sel;
        end
    end

    assign wr_sel = !s_sync[1] && !iow_sync[1] && addr;
    assign push   = wr_sel && !wr_sel_d;
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign pop    = (state == IDLE) && !empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle
    assign accept = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            if (accept && !pop)
                count <= count + CNT_W'(1);
            else if (!accept && pop)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= data;
    end

    // Consumer handshake: byte_out is loaded only when leaving IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            byte_out <= 8'h00;
            dav_     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        byte_out <= mem[rd_ptr];
                        state    <= PRESENT;
                    end
                end
                PRESENT: begin
                    dav_  <= 1'b0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!rfd_sync[1]) begin
                        dav_  <= 1'b1;
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (rfd_sync[1]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IO_OUT_OVERRUN_EN
    logic [1:0] ior_sync;
    logic       rd_sel;
    logic       rd_sel_d;

    assign rd_sel = !s_sync[1] && !ior_sync[1] && !addr;

    // Sticky drop flag; cleared once per STATUS read, after that read has seen it
    always_ff @(posedge clock) begin
        if (reset) begin
            ior_sync <= 2'b11;
            rd_sel_d <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            ior_sync <= {ior_sync[0], ior_};
            rd_sel_d <= rd_sel;
            if (push && full && !pop)
                overrun <= 1'b1;
            else if (rd_sel && !rd_sel_d)
                overrun <= 1'b0;
        end
    end
`else
    assign overrun = 1'b0;
`endif

    assign rd_data = addr ? 8'h00 : {overrun, 5'b0, empty, !full};
    assign data    = (!s_ && !ior_) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_io_out_hs_fifo.sv
// Randomised bench for io_out_hs_fifo: bus initiator tasks, a responding consumer,
// and a queue-based scoreboard of the bytes the consumer should receive.
`timescale 1ns/1ps
module tb_io_out_hs_fifo;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       s_    = 1'b1;
    logic       ior_  = 1'b1;
    logic       iow_  = 1'b1;
    logic       addr  = 1'b0;
    logic       rfd   = 1'b1;
    logic [7:0] drv_val = 8'h00;
    logic       drv_en  = 1'b0;
    wire  [7:0] data;
    logic [7:0] byte_out;
    logic       dav_;

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    bit         cons_en    = 1'b0;
    bit         cons_rand  = 1'b0;
    int         cons_delay = 3;

    assign data = drv_en ? drv_val : 8'hzz;

    always #5 clock = ~clock;

    io_out_hs_fifo dut (
        .clock    (clock),
        .reset    (reset),
        .s_       (s_),
        .ior_     (ior_),
        .iow_     (iow_),
        .addr     (addr),
        .data     (data),
        .byte_out (byte_out),
        .dav_     (dav_),
        .rfd      (rfd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_write(input logic [7:0] v, input int hold);
        addr = 1'b1; drv_val = v; drv_en = 1'b1; s_ = 1'b0; iow_ = 1'b0;
        tick(hold);
        iow_ = 1'b1; s_ = 1'b1;
        tick(1);
        drv_en = 1'b0;
        tick(3);
    endtask

    task automatic read_status(output logic [7:0] v);
        addr = 1'b0; s_ = 1'b0; ior_ = 1'b0;
        #1 v = data;
        tick(2);
        s_ = 1'b1; ior_ = 1'b1;
        tick(3);
    endtask

    // Consumer: record each presented byte, acknowledge after a delay, check it holds
    int         c_delay;
    int         c_k;
    logic [7:0] c_b;
    initial begin
        forever begin
            @(negedge clock);
            if (cons_en && dav_ === 1'b0) begin
                c_b = byte_out;
                got.push_back(c_b);
                c_delay = cons_rand ? int'($urandom_range(0, 4)) : cons_delay;
                repeat (c_delay) begin
                    @(negedge clock);
                    check("byte_hold", byte_out, c_b);
                end
                rfd = 1'b0;
                c_k = 0;
                while (dav_ !== 1'b1 && c_k < 30) begin
                    @(negedge clock);
                    c_k++;
                end
                check("ack_dav_rise", dav_, 1);
                rfd = 1'b1;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st;
        logic [7:0] v;
        int         idx;
        int         k;

        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);

        check("rst_dav", dav_, 1);
        check("rst_byte", byte_out, 8'h00);
        read_status(st);
        check("rst_status", st, 8'h03);

        addr = 1'b1; s_ = 1'b0; ior_ = 1'b0;
        #1 check("data_reg_read", data, 8'h00);
        tick(1);
        s_ = 1'b1; ior_ = 1'b1;
        tick(3);

        // Single byte: latency and one full handshake
        cons_en = 1'b1; cons_rand = 1'b0; cons_delay = 3;
        got.delete();
        addr = 1'b1; drv_val = 8'h2A; drv_en = 1'b1; s_ = 1'b0; iow_ = 1'b0;
        idx = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (i == 4) begin iow_ = 1'b1; s_ = 1'b1; end
            if (i == 5) drv_en = 1'b0;
            if (idx == 0 && dav_ === 1'b0) idx = i;
        end
        check("dav_latency", idx, 5);
        k = 0;
        while (!(got.size() >= 1 && dav_ === 1'b1 && rfd === 1'b1) && k < 60) begin
            tick(1);
            k++;
        end
        tick(4);
        check("hs_count", got.size(), 1);
        check("hs_byte", got[0], 8'h2A);
        check("byte_after_ack", byte_out, 8'h2A);
        read_status(st);
        check("status_after_hs", st, 8'h03);

        // Stalled consumer: fill FIFO, drop one, then drain
        cons_en = 1'b0;
        got.delete();
        for (int i = 1; i <= 5; i++) bus_write(8'(i), 4);
        check("stall_byte", byte_out, 8'h01);
        check("stall_dav", dav_, 0);
        read_status(st);
        check("status_full", st, 8'h00);
        bus_write(8'hFF, 4);
        read_status(st);
`ifdef IO_OUT_OVERRUN_EN
        check("status_overrun", st, 8'h80);
`else
        check("status_overrun", st, 8'h00);
`endif
        read_status(st);
        check("status_overrun_clr", st, 8'h00);
        cons_en = 1'b1;
        k = 0;
        while (got.size() < 5 && k < 400) begin
            tick(1);
            k++;
        end
        tick(30);
        check("drain_count", got.size(), 5);
        for (int i = 0; i < 5; i++) check("drain_byte", got[i], 32'(i + 1));
        read_status(st);
        check("status_drained", st, 8'h03);

        // Polling initiator with randomised consumer timing
        got.delete();
        exp_q.delete();
        cons_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            k = 0;
            do begin
                read_status(st);
                k++;
            end while (st[0] !== 1'b1 && k < 50);
            check("poll_fo", st[0], 1);
            v = 8'(i * i + 5);
            exp_q.push_back(v);
            bus_write(v, 4);
            tick(int'($urandom_range(0, 3)));
        end
        k = 0;
        while (got.size() < exp_q.size() && k < 2000) begin
            tick(1);
            k++;
        end
        tick(40);
        check("seq_len", got.size(), exp_q.size());
        for (int i = 0; i < 30; i++) check("seq_byte", got[i], exp_q[i]);

        // Reset in the middle of a handshake with bytes queued
        cons_en = 1'b0; cons_rand = 1'b0;
        bus_write(8'h10, 4);
        bus_write(8'h11, 4);
        bus_write(8'h12, 4);
        check("pre_rst_dav", dav_, 0);
        check("pre_rst_byte", byte_out, 8'h10);
        read_status(st);
        check("pre_rst_status", st, 8'h01);
        reset = 1'b1;
        tick(1);
        check("mid_rst_dav", dav_, 1);
        check("mid_rst_byte", byte_out, 8'h00);
        reset = 1'b0;
        tick(1);
        read_status(st);
        check("post_rst_status", st, 8'h03);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (dav_ !== 1'b1) k++;
        end
        check("post_rst_quiet", k, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
